mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 113 +++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding requester-to-byte-memory access controller
// Range-checks each request, sequences memory strobes and holds one response until accepted.
module mem_access_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_we,
   input  logic [15:0]          req_addr,
   input  logic [15:0]          req_wdata,
   output logic                 req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [15:0]          rsp_data,
   output logic                 rsp_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [15:0]          mem_address,
   output logic [15:0]          mem_din,
   input  logic [15:0]          mem_dout
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_CAPT,
      ST_WR_ISSUE,
      ST_RESP
   } state_t;

   // One extra bit so a depth of 65536 still compares correctly.
   localparam logic [16:0] LP_DEPTH = 17'(MEM_DEPTH);

   state_t r_state;
   logic   w_in_range;

   assign w_in_range = ({1'b0, req_addr} < LP_DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= 16'h0000;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= 16'h0000;
         mem_din     <= 16'h0000;
         err_count   <= '0;
      end else begin
         // Strobes are single-cycle pulses; only the issuing transition raises one.
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (!w_in_range) begin
                     r_state   <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= 16'hFFFF;
                     if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                     end
                  end else if (req_we) begin
                     r_state     <= ST_WR_ISSUE;
                     mem_write   <= 1'b1;
                     mem_address <= req_addr;
                     mem_din     <= req_wdata;
                  end else begin
                     r_state     <= ST_RD_ISSUE;
                     mem_read    <= 1'b1;
                     mem_address <= req_addr;
                  end
               end
            end
            ST_RD_ISSUE: begin
               r_state <= ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
               r_state   <= ST_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= mem_dout;
            end
            ST_WR_ISSUE: begin
               r_state   <= ST_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= 16'h0000;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_state   <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
// Expected responses come from a byte-array model, a saturating error tally and fixed per-kind latencies.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [15:0] req_wdata = 16'h0;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic [7:0]  err_count;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_din;
   logic [15:0] mem_dout = 16'h0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.MEM_DEPTH(256), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .err_count(err_count),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Byte memory device attached to the controller.
   logic [7:0] dev_mem [256];
   // Reference model state.
   logic [7:0] ref_mem [256];
   int         ref_errs;

   int n_checks = 0;
   int n_errors = 0;

   int rd_pulses = 0;
   int wr_pulses = 0;
   int overlaps = 0;
   int cyc = 0;
   logic [15:0] last_addr = 16'h0;
   logic [15:0] last_din = 16'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_read && mem_write) overlaps <= overlaps + 1;
      if (mem_read) begin
         rd_pulses <= rd_pulses + 1;
         last_addr <= mem_address;
         mem_dout  <= {8'h00, dev_mem[mem_address[7:0]]};
      end
      if (mem_write) begin
         wr_pulses <= wr_pulses + 1;
         last_addr <= mem_address;
         last_din  <= mem_din;
         dev_mem[mem_address[7:0]] <= mem_din[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic do_txn(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int hold);
      int rd0, wr0, lat, exp_lat, guard;
      bit in_range;
      logic [15:0] exp_data, cap_data;
      logic cap_err;
      in_range = (addr < 16'd256);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      rsp_ready = 1'b0;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("accept_timeout", 32'(guard < 20), 32'd1);
      rd0 = rd_pulses; wr0 = wr_pulses;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!in_range) begin
         exp_lat = 1; exp_data = 16'hFFFF;
         if (ref_errs < 255) ref_errs++;
      end else if (we) begin
         exp_lat = 2; exp_data = 16'h0000;
         ref_mem[addr[7:0]] = wdata[7:0];
      end else begin
         exp_lat = 3; exp_data = {8'h00, ref_mem[addr[7:0]]};
      end
      check("rsp_latency", 32'(lat), 32'(exp_lat));
      check("rsp_data", 32'(rsp_data), 32'(exp_data));
      check("rsp_err", 32'(rsp_err), 32'(!in_range));
      check("err_count", 32'(err_count), 32'(ref_errs));
      check("rd_pulses", 32'(rd_pulses - rd0), 32'(in_range && !we));
      check("wr_pulses", 32'(wr_pulses - wr0), 32'(in_range && we));
      if (in_range) check("strobe_addr", 32'(last_addr), 32'(addr));
      if (in_range && we) check("strobe_din", 32'(last_din), 32'(wdata));
      cap_data = rsp_data; cap_err = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_data", 32'(rsp_data), 32'(cap_data));
         check("hold_err", 32'(rsp_err), 32'(cap_err));
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_valid", 32'(rsp_valid), 32'd0);
      check("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      int prev_cyc, stale, guard;
      bit prev_we, cur_we;
      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = 8'(i * 37 + 11);
         ref_mem[i] = 8'(i * 37 + 11);
      end
      dev_mem[5] = 8'h2B;
      ref_mem[5] = 8'h2B;
      ref_errs = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);

      do_txn(1'b0, 16'd5, 16'h0000, 0);
      do_txn(1'b1, 16'd200, 16'h12A7, 0);
      do_txn(1'b0, 16'd200, 16'h0000, 0);
      check("rd200_value", 32'(rsp_data), 32'h00A7);
      do_txn(1'b0, 16'h0100, 16'h0000, 0);
      check("first_err_count", 32'(err_count), 32'd1);
      do_txn(1'b0, 16'd17, 16'h0000, 5);
      do_txn(1'b1, 16'hFFFF, 16'hBEEF, 2);

      for (int i = 0; i < 60; i++) begin
         logic [15:0] a;
         if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(256, 65535));
         else a = 16'($urandom_range(0, 255));
         do_txn(1'($urandom_range(0, 1)), a, 16'($urandom), int'($urandom_range(0, 3)));
      end

      for (int i = 0; i < 300; i++) begin
         do_txn(1'($urandom_range(0, 1)), 16'($urandom_range(256, 65535)), 16'h0, 0);
      end
      check("err_saturated", 32'(err_count), 32'd255);

      // Reset while the read strobe is out.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd9;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_mem_read", 32'(mem_read), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ref_errs = 0;
      check("abort_mem_read", 32'(mem_read), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_err_count", 32'(err_count), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      stale = 0;
      rsp_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) stale++;
      end
      check("abort_no_stale", 32'(stale), 32'd0);

      // Back-to-back alternating traffic with everything held open.
      rsp_ready = 1'b1;
      prev_cyc = 0;
      prev_we = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cur_we = 1'(i % 2);
         req_valid = 1'b1; req_we = cur_we;
         req_addr = 16'($urandom_range(0, 255)); req_wdata = 16'($urandom);
         guard = 0;
         while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         check("b2b_timeout", 32'(guard < 20), 32'd1);
         if (i > 0) check("b2b_spacing", 32'(cyc - prev_cyc), prev_we ? 32'd3 : 32'd4);
         prev_cyc = cyc;
         prev_we = cur_we;
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("strobe_overlap", 32'(overlaps), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
